// File: rtl/friscv_axi_rd_arbiter.sv
// rtl/friscv_axi_rd_arbiter.sv - two-port AXI4 read arbiter with in-order R routing
// Optional macro ARB_FIXED_PRIO_EN: port 1 wins ties instead of round-robin.
module friscv_axi_rd_arbiter #(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_W    = 8,
  parameter int AXI_DATA_W  = 128,
  parameter int OSTDREQ_NUM = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s0_arvalid,
  output logic                          s0_arready,
  input  logic [AXI_ADDR_W-1:0]         s0_araddr,
  input  logic [7:0]                    s0_arlen,
  input  logic [2:0]                    s0_arsize,
  input  logic [1:0]                    s0_arburst,
  input  logic [2:0]                    s0_arprot,
  input  logic [AXI_ID_W-1:0]           s0_arid,
  output logic                          s0_rvalid,
  input  logic                          s0_rready,
  output logic [AXI_ID_W-1:0]           s0_rid,
  output logic [1:0]                    s0_rresp,
  output logic [AXI_DATA_W-1:0]         s0_rdata,
  output logic                          s0_rlast,
  input  logic                          s1_arvalid,
  output logic                          s1_arready,
  input  logic [AXI_ADDR_W-1:0]         s1_araddr,
  input  logic [7:0]                    s1_arlen,
  input  logic [2:0]                    s1_arsize,
  input  logic [1:0]                    s1_arburst,
  input  logic [2:0]                    s1_arprot,
  input  logic [AXI_ID_W-1:0]           s1_arid,
  output logic                          s1_rvalid,
  input  logic                          s1_rready,
  output logic [AXI_ID_W-1:0]           s1_rid,
  output logic [1:0]                    s1_rresp,
  output logic [AXI_DATA_W-1:0]         s1_rdata,
  output logic                          s1_rlast,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [AXI_ADDR_W-1:0]         m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  output logic [2:0]                    m_arprot,
  output logic [AXI_ID_W-1:0]           m_arid,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [AXI_ID_W-1:0]           m_rid,
  input  logic [1:0]                    m_rresp,
  input  logic [AXI_DATA_W-1:0]         m_rdata,
  input  logic                          m_rlast,
  output logic [$clog2(OSTDREQ_NUM):0]  ostd_cnt,
  output logic                          rsp_err
);

  localparam int PTR_W = $clog2(OSTDREQ_NUM);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                 state_q;
  logic                   grant_q;
`ifndef ARB_FIXED_PRIO_EN
  logic                   rr_q;
`endif
  logic [OSTDREQ_NUM-1:0] order_q, order_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rsp_err_q, rsp_err_d;

  logic fifo_full, fifo_empty;
  logic arb_win, sel, ar_req, ar_hs;
  logic head, r_pop;

  assign fifo_full  = (cnt_q == CNT_W'(OSTDREQ_NUM));
  assign fifo_empty = (cnt_q == '0);

  // Winner for a fresh arbitration; only consulted in IDLE.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    arb_win = s1_arvalid;
`else
    arb_win = rr_q ? s1_arvalid : !s0_arvalid;
`endif
  end

  assign sel    = (state_q == LOCK) ? grant_q : arb_win;
  assign ar_req = (state_q == LOCK) || (!fifo_full && (s0_arvalid || s1_arvalid));
  assign ar_hs  = m_arvalid && m_arready;

  assign m_arvalid  = aresetn && ar_req;
  assign s0_arready = ar_hs && !sel;
  assign s1_arready = ar_hs && sel;

  assign m_araddr  = sel ? s1_araddr  : s0_araddr;
  assign m_arlen   = sel ? s1_arlen   : s0_arlen;
  assign m_arsize  = sel ? s1_arsize  : s0_arsize;
  assign m_arburst = sel ? s1_arburst : s0_arburst;
  assign m_arprot  = sel ? s1_arprot  : s0_arprot;
  assign m_arid    = sel ? s1_arid    : s0_arid;

  // R beats follow the oldest accepted AR; with nothing pending they are drained.
  assign head      = order_q[rd_ptr_q];
  assign s0_rvalid = aresetn && !fifo_empty && !head && m_rvalid;
  assign s1_rvalid = aresetn && !fifo_empty && head && m_rvalid;
  assign m_rready  = aresetn && (fifo_empty || (head ? s1_rready : s0_rready));
  assign r_pop     = m_rvalid && m_rready && m_rlast && !fifo_empty;

  assign s0_rid   = m_rid;
  assign s0_rresp = m_rresp;
  assign s0_rdata = m_rdata;
  assign s0_rlast = m_rlast;
  assign s1_rid   = m_rid;
  assign s1_rresp = m_rresp;
  assign s1_rdata = m_rdata;
  assign s1_rlast = m_rlast;

  always_comb begin
    order_d   = order_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rsp_err_d = rsp_err_q || (m_rvalid && fifo_empty);
    if (ar_hs) begin
      order_d[wr_ptr_q] = sel;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (r_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, ar_hs} - {{(CNT_W-1){1'b0}}, r_pop};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q      <= 1'b0;
`endif
      order_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_req && !m_arready) begin
            state_q <= LOCK;
            grant_q <= arb_win;
          end
        end
        LOCK: begin
          if (m_arready) begin
            state_q <= IDLE;
          end
        end
      endcase
`ifndef ARB_FIXED_PRIO_EN
      if (ar_hs) begin
        rr_q <= !sel;
      end
`endif
      order_q   <= order_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign ostd_cnt = cnt_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_friscv_axi_rd_arbiter.sv
// tb/tb_friscv_axi_rd_arbiter.sv - self-checking bench for friscv_axi_rd_arbiter
module tb_friscv_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int IW = 8;
  localparam int DW = 128;
  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic          s0_arvalid, s0_arready, s1_arvalid, s1_arready;
  logic [AW-1:0] s0_araddr, s1_araddr, m_araddr;
  logic [7:0]    s0_arlen, s1_arlen, m_arlen;
  logic [2:0]    s0_arsize, s1_arsize, m_arsize;
  logic [1:0]    s0_arburst, s1_arburst, m_arburst;
  logic [2:0]    s0_arprot, s1_arprot, m_arprot;
  logic [IW-1:0] s0_arid, s1_arid, m_arid;
  logic          s0_rvalid, s0_rready, s1_rvalid, s1_rready;
  logic [IW-1:0] s0_rid, s1_rid, m_rid;
  logic [1:0]    s0_rresp, s1_rresp, m_rresp;
  logic [DW-1:0] s0_rdata, s1_rdata, m_rdata;
  logic          s0_rlast, s1_rlast, m_rlast;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [CW-1:0] ostd_cnt;
  logic          rsp_err;

  int errors = 0;
  int checks = 0;
  int rr_exp;

  friscv_axi_rd_arbiter #(
    .AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW), .OSTDREQ_NUM(N)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arprot(s0_arprot), .s0_arid(s0_arid),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rid(s0_rid),
    .s0_rresp(s0_rresp), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arprot(s1_arprot), .s1_arid(s1_arid),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rid(s1_rid),
    .s1_rresp(s1_rresp), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arprot(m_arprot), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .ostd_cnt(ostd_cnt), .rsp_err(rsp_err)
  );

  // Arbitration rule: RR pointer port if requesting, else the other; fixed mode favours port 1.
  function automatic int pick(logic a0, logic a1);
`ifdef ARB_FIXED_PRIO_EN
    return a1 ? 1 : 0;
`else
    if (rr_exp == 1) return a1 ? 1 : 0;
    return a0 ? 0 : 1;
`endif
  endfunction

  task automatic drive_idle();
    s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd4; s0_arburst = 2'd1;
    s0_arprot = '0; s0_arid = '0; s0_rready = 0;
    s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd4; s1_arburst = 2'd1;
    s1_arprot = '0; s1_arid = '0; s1_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rid = '0; m_rresp = '0; m_rdata = '0; m_rlast = 0;
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 0;
    drive_idle();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1;
    rr_exp = 0;
  endtask

  task automatic test_reset();
    aresetn = 0;
    drive_idle();
    s0_arvalid = 1; s1_arvalid = 1; m_arready = 1; m_rvalid = 1; m_rlast = 1;
    s0_rready = 1; s1_rready = 1;
    @(negedge aclk);
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_m_arvalid got %0b want 0", m_arvalid); end
    checks++; if ({s0_arready, s1_arready} !== 2'b00) begin errors++; $display("FAIL reset_arready got %b want 00", {s0_arready, s1_arready}); end
    checks++; if ({s0_rvalid, s1_rvalid, m_rready} !== 3'b000) begin errors++; $display("FAIL reset_r got %b want 000", {s0_rvalid, s1_rvalid, m_rready}); end
    next_cycle();
    checks++; if (ostd_cnt !== '0) begin errors++; $display("FAIL reset_ostd got %0d want 0", ostd_cnt); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %0b want 0", rsp_err); end
  endtask

  task automatic test_single_read();
    do_reset();
    s0_arvalid = 1; s0_araddr = 32'h100; s0_arlen = 0; s0_arid = 8'h11; m_arready = 1;
    @(negedge aclk);
    checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h100) begin errors++; $display("FAIL single_ar got v=%0b a=%0h want v=1 a=100", m_arvalid, m_araddr); end
    checks++; if ({s0_arready, s1_arready} !== 2'b10) begin errors++; $display("FAIL single_arready got %b want 10", {s0_arready, s1_arready}); end
    checks++; if (m_arid !== 8'h11) begin errors++; $display("FAIL single_arid got %0h want 11", m_arid); end
    next_cycle();
    s0_arvalid = 0; m_arready = 0;
    checks++; if (ostd_cnt !== CW'(1)) begin errors++; $display("FAIL single_ostd1 got %0d want 1", ostd_cnt); end
    m_rvalid = 1; m_rdata = {16{8'hA5}}; m_rlast = 1; m_rid = 8'h11; s0_rready = 1;
    @(negedge aclk);
    checks++; if ({s0_rvalid, s1_rvalid} !== 2'b10) begin errors++; $display("FAIL single_rvalid got %b want 10", {s0_rvalid, s1_rvalid}); end
    checks++; if (s0_rdata !== {16{8'hA5}} || s0_rid !== 8'h11) begin errors++; $display("FAIL single_rdata got %0h want a5..", s0_rdata); end
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL single_rready got %0b want 1", m_rready); end
    next_cycle();
    m_rvalid = 0; m_rlast = 0;
    checks++; if (ostd_cnt !== CW'(0)) begin errors++; $display("FAIL single_ostd0 got %0d want 0", ostd_cnt); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err got %0b want 0", rsp_err); end
  endtask

  task automatic test_rr_alternate();
    int exp_g;
    do_reset();
    s0_arvalid = 1; s0_araddr = 32'h1000; s1_arvalid = 1; s1_araddr = 32'h2000; m_arready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      exp_g = pick(1'b1, 1'b1);
      checks++; if ({s1_arready, s0_arready} !== (exp_g == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d got s1,s0=%b want port %0d", i, {s1_arready, s0_arready}, exp_g); end
      checks++; if (m_araddr !== (exp_g == 1 ? 32'h2000 : 32'h1000)) begin errors++; $display("FAIL rr_addr%0d got %0h want port %0d addr", i, m_araddr, exp_g); end
      rr_exp = 1 - exp_g;
      next_cycle();
    end
    s0_arvalid = 0; s1_arvalid = 0; m_arready = 0;
    checks++; if (ostd_cnt !== CW'(4)) begin errors++; $display("FAIL rr_ostd got %0d want 4", ostd_cnt); end
  endtask

  task automatic test_lock_hold();
    do_reset();
    s0_arvalid = 1; s0_araddr = 32'h300; m_arready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h300) begin errors++; $display("FAIL lock_hold%0d got v=%0b a=%0h want v=1 a=300", i, m_arvalid, m_araddr); end
      checks++; if ({s0_arready, s1_arready} !== 2'b00) begin errors++; $display("FAIL lock_ready%0d got %b want 00", i, {s0_arready, s1_arready}); end
      next_cycle();
      s1_arvalid = 1; s1_araddr = 32'h400;
    end
    m_arready = 1;
    @(negedge aclk);
    checks++; if ({s0_arready, s1_arready} !== 2'b10 || m_araddr !== 32'h300) begin errors++; $display("FAIL lock_accept got rdy=%b a=%0h want 10/300", {s0_arready, s1_arready}, m_araddr); end
    next_cycle();
    s0_arvalid = 0;
    @(negedge aclk);
    checks++; if ({s0_arready, s1_arready} !== 2'b01 || m_araddr !== 32'h400) begin errors++; $display("FAIL lock_next got rdy=%b a=%0h want 01/400", {s0_arready, s1_arready}, m_araddr); end
    next_cycle();
    s1_arvalid = 0; m_arready = 0;
    checks++; if (ostd_cnt !== CW'(2)) begin errors++; $display("FAIL lock_ostd got %0d want 2", ostd_cnt); end
  endtask

  task automatic test_full();
    do_reset();
    s0_arvalid = 1; m_arready = 1;
    repeat (N) next_cycle();
    checks++; if (ostd_cnt !== CW'(N)) begin errors++; $display("FAIL full_ostd got %0d want %0d", ostd_cnt, N); end
    @(negedge aclk);
    checks++; if (m_arvalid !== 1'b0 || s0_arready !== 1'b0) begin errors++; $display("FAIL full_block got v=%0b r=%0b want 0/0", m_arvalid, s0_arready); end
    next_cycle();
    m_rvalid = 1; m_rlast = 1; s0_rready = 1;
    @(negedge aclk);
    checks++; if (m_arvalid !== 1'b0 || s0_rvalid !== 1'b1) begin errors++; $display("FAIL full_pop_cycle got arv=%0b rv=%0b want 0/1", m_arvalid, s0_rvalid); end
    next_cycle();
    m_rvalid = 0; m_rlast = 0;
    checks++; if (ostd_cnt !== CW'(N-1)) begin errors++; $display("FAIL full_after_pop got %0d want %0d", ostd_cnt, N-1); end
    @(negedge aclk);
    checks++; if (m_arvalid !== 1'b1 || s0_arready !== 1'b1) begin errors++; $display("FAIL full_regrant got v=%0b r=%0b want 1/1", m_arvalid, s0_arready); end
    next_cycle();
    s0_arvalid = 0; m_arready = 0;
    checks++; if (ostd_cnt !== CW'(N)) begin errors++; $display("FAIL full_refill got %0d want %0d", ostd_cnt, N); end
  endtask

  task automatic test_burst_routing();
    int q[$];
    int beat, cyc, h;
    int got0, got1;
    do_reset();
    q = '{0, 1, 0};
    foreach (q[i]) begin
      if (q[i] == 0) begin s0_arvalid = 1; s0_arlen = 3; end
      else begin s1_arvalid = 1; s1_arlen = 3; end
      m_arready = 1;
      next_cycle();
      s0_arvalid = 0; s1_arvalid = 0; m_arready = 0;
    end
    beat = 0; cyc = 0; got0 = 0; got1 = 0;
    m_rdata = {$urandom, $urandom, $urandom, $urandom};
    while (q.size() > 0 && cyc < 200) begin
      m_rvalid = 1; m_rlast = (beat == 3);
      s0_rready = cyc[0];
      s1_rready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      h = q[0];
      checks++; if ({s1_rvalid, s0_rvalid} !== (h == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL burst_route got s1,s0=%b want head %0d", {s1_rvalid, s0_rvalid}, h); end
      checks++; if (m_rready !== (h == 1 ? s1_rready : s0_rready)) begin errors++; $display("FAIL burst_rready got %0b want head %0d rready", m_rready, h); end
      checks++; if ((h == 1 ? s1_rdata : s0_rdata) !== m_rdata) begin errors++; $display("FAIL burst_rdata got %0h want %0h", (h == 1 ? s1_rdata : s0_rdata), m_rdata); end
      if (s0_rvalid && s0_rready) got0++;
      if (s1_rvalid && s1_rready) got1++;
      if (h == 1 ? s1_rready : s0_rready) begin
        if (beat == 3) begin beat = 0; void'(q.pop_front()); end
        else beat++;
      end
      next_cycle();
      if (m_rready === 1'b1 || cyc == 0) m_rdata = {$urandom, $urandom, $urandom, $urandom};
      cyc++;
    end
    m_rvalid = 0; m_rlast = 0; s0_rready = 0; s1_rready = 0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL burst_timeout got %0d bursts left want 0", q.size()); end
    checks++; if (got0 != 8 || got1 != 4) begin errors++; $display("FAIL burst_count got %0d/%0d want 8/4", got0, got1); end
    checks++; if (ostd_cnt !== CW'(0)) begin errors++; $display("FAIL burst_ostd got %0d want 0", ostd_cnt); end
  endtask

  task automatic test_rsp_err();
    do_reset();
    m_rvalid = 1; m_rlast = 1;
    @(negedge aclk);
    checks++; if (m_rready !== 1'b1 || s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0) begin errors++; $display("FAIL err_drain got rr=%0b rv=%b want 1/00", m_rready, {s0_rvalid, s1_rvalid}); end
    next_cycle();
    m_rvalid = 0; m_rlast = 0;
    checks++; if (rsp_err !== 1'b1 || ostd_cnt !== CW'(0)) begin errors++; $display("FAIL err_set got err=%0b ostd=%0d want 1/0", rsp_err, ostd_cnt); end
    repeat (3) next_cycle();
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", rsp_err); end
    aresetn = 0;
    next_cycle();
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", rsp_err); end
    aresetn = 1;
  endtask

  task automatic test_random();
    int ordq[$];
    int lenq[$];
    int beat, lock, g, h;
    logic acc0, acc1, hs;
    do_reset();
    beat = 0; lock = -1; acc0 = 0; acc1 = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (acc0) s0_arvalid = 0;
      if (acc1) s1_arvalid = 0;
      acc0 = 0; acc1 = 0;
      if (!s0_arvalid && $urandom_range(0, 2) == 0) begin
        s0_arvalid = 1; s0_araddr = $urandom; s0_arlen = 8'($urandom_range(0, 3)); s0_arid = 8'($urandom);
      end
      if (!s1_arvalid && $urandom_range(0, 2) == 0) begin
        s1_arvalid = 1; s1_araddr = $urandom; s1_arlen = 8'($urandom_range(0, 3)); s1_arid = 8'($urandom);
      end
      m_arready = 1'($urandom_range(0, 1));
      s0_rready = ($urandom_range(0, 3) != 0);
      s1_rready = ($urandom_range(0, 3) != 0);
      m_rvalid  = (ordq.size() > 0) && ($urandom_range(0, 3) != 0);
      m_rlast   = (ordq.size() > 0) && (beat == lenq[0]);
      m_rdata   = {$urandom, $urandom, $urandom, $urandom};
      m_rid     = 8'($urandom);
      @(negedge aclk);
      if (lock >= 0) g = lock;
      else if (ordq.size() < N && (s0_arvalid || s1_arvalid)) g = pick(s0_arvalid, s1_arvalid);
      else g = -1;
      checks++; if (m_arvalid !== (g >= 0)) begin errors++; $display("FAIL rnd_arvalid c%0d got %0b want %0b", cyc, m_arvalid, g >= 0); end
      checks++; if ({s1_arready, s0_arready} !== {(g == 1) && m_arready, (g == 0) && m_arready}) begin errors++; $display("FAIL rnd_arready c%0d got %b want grant %0d", cyc, {s1_arready, s0_arready}, g); end
      if (g >= 0) begin
        checks++; if (m_araddr !== (g == 1 ? s1_araddr : s0_araddr)) begin errors++; $display("FAIL rnd_araddr c%0d got %0h want port %0d", cyc, m_araddr, g); end
      end
      checks++; if (ostd_cnt !== CW'(ordq.size())) begin errors++; $display("FAIL rnd_ostd c%0d got %0d want %0d", cyc, ostd_cnt, ordq.size()); end
      hs = 0;
      if (ordq.size() > 0) begin
        h = ordq[0];
        checks++; if ({s1_rvalid, s0_rvalid} !== {(h == 1) && m_rvalid, (h == 0) && m_rvalid}) begin errors++; $display("FAIL rnd_rvalid c%0d got %b want head %0d", cyc, {s1_rvalid, s0_rvalid}, h); end
        checks++; if (m_rready !== (h == 1 ? s1_rready : s0_rready)) begin errors++; $display("FAIL rnd_rready c%0d got %0b", cyc, m_rready); end
        hs = m_rvalid && (h == 1 ? s1_rready : s0_rready);
      end else begin
        checks++; if (m_rready !== 1'b1 || s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0) begin errors++; $display("FAIL rnd_empty c%0d got rr=%0b", cyc, m_rready); end
      end
      if (hs) begin
        if (m_rlast) begin beat = 0; void'(ordq.pop_front()); void'(lenq.pop_front()); end
        else beat++;
      end
      if (g >= 0) begin
        if (m_arready) begin
          ordq.push_back(g);
          lenq.push_back(g == 1 ? int'(s1_arlen) : int'(s0_arlen));
          rr_exp = 1 - g;
          lock = -1;
          if (g == 1) acc1 = 1; else acc0 = 1;
        end else begin
          lock = g;
        end
      end
      next_cycle();
    end
    drive_idle();
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rnd_rsp_err got %0b want 0", rsp_err); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_rr_alternate();
    test_lock_hold();
    test_full();
    test_burst_routing();
    test_rsp_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/friscv_axi_rd_arbiter.md
Name: friscv_axi_rd_arbiter

Overview:
- Shares one AXI4 read master port (toward the instruction/data memory) between two requesters: port 0 = icache memory side, port 1 = dcache/secondary reader.
- Arbitrates the AR channel and routes R beats back to the issuing port in AR acceptance order, using an internal order FIFO.
- Sits between the cache AXI master ports and the memory read port (e.g. p1 of the shared RAM).

Parameters:
- AXI_ADDR_W, 32, address width.
- AXI_ID_W, 8, ID width; IDs pass through unchanged.
- AXI_DATA_W, 128, R data width.
- OSTDREQ_NUM, 8, max outstanding reads across both ports; order FIFO depth (power of 2, >=2).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- s0_arvalid/s1_arvalid  in  1  requester AR valid.
- s0_arready/s1_arready  out  1  requester AR ready.
- s0_araddr/s1_araddr  in  AXI_ADDR_W  read address.
- s0_arlen/s1_arlen  in  8  burst length.
- s0_arsize/s1_arsize  in  3  beat size.
- s0_arburst/s1_arburst  in  2  burst type.
- s0_arprot/s1_arprot  in  3  protection.
- s0_arid/s1_arid  in  AXI_ID_W  ID.
- s0_rvalid/s1_rvalid  out  1  routed R valid.
- s0_rready/s1_rready  in  1  requester R ready.
- s0_rid/s1_rid  out  AXI_ID_W  routed rid.
- s0_rresp/s1_rresp  out  2  routed rresp.
- s0_rdata/s1_rdata  out  AXI_DATA_W  routed rdata.
- s0_rlast/s1_rlast  out  1  routed rlast.
- m_arvalid  out  1  master AR valid.
- m_arready  in  1  master AR ready.
- m_araddr, m_arlen, m_arsize, m_arburst, m_arprot, m_arid  out  as on s*  muxed AR fields.
- m_rvalid  in  1  master R valid.
- m_rready  out  1  master R ready.
- m_rid  in  AXI_ID_W  master rid.
- m_rresp  in  2  master rresp.
- m_rdata  in  AXI_DATA_W  master rdata.
- m_rlast  in  1  master rlast.
- ostd_cnt  out  $clog2(OSTDREQ_NUM)+1  outstanding reads.
- rsp_err  out  1  sticky error: R beat with empty order FIFO.

Behaviour:
- Reset (aresetn=0 at posedge): FIFO empty, ostd_cnt=0, rsp_err=0, RR pointer=port 0, grant state IDLE. All *ready/*valid outputs are 0 while reset is held.
- AR arbitration FSM:
  - IDLE: if FIFO not full and any s*_arvalid, grant the winner. The winner is the port pointed to by the RR pointer if it requests, else the other port. The decision is combinational in the same cycle; m_arvalid=1 and the winner's AR fields are muxed.
  - If m_arready=1 the same cycle: s{g}_arready=1, push g into the FIFO, toggle the RR pointer to !g, stay IDLE.
  - Else go to LOCK.
  - LOCK: hold the grant g and m_arvalid=1 (AXI stability; no re-arbitration) until m_arready. Then push g, pointer=!g, go to IDLE.
  - The loser's arready stays 0.
- FIFO full (ostd_cnt==OSTDREQ_NUM): m_arvalid=0, both arready=0. LOCK is never entered while full.
- R routing:
  - head = FIFO front. If the FIFO is non-empty: s{head}_rvalid=m_rvalid, m_rready=s{head}_rready. The other port has rvalid=0.
  - rid/rresp/rdata/rlast are forwarded to both ports (qualified by rvalid).
  - Pop on m_rvalid&&m_rready&&m_rlast. Multi-beat bursts stay routed to head until rlast.
- Empty FIFO with m_rvalid=1: m_rready=1 (drain/drop the beat), rsp_err set (sticky until reset), no pop.
- Simultaneous push and pop in one cycle: ostd_cnt unchanged. The push into a full FIFO is impossible because granting is blocked; a pop frees the slot at the next cycle.
- FIFO pointers are $clog2(OSTDREQ_NUM) bits wide and wrap modulo depth.
- Reset mid-burst: all state is cleared. Requesters are reset by the same aresetn.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: port 1 always wins when both request in IDLE; the RR pointer is unused. LOCK behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single s0 read, addr 0x100, arlen 0, m_arready=1 -> m_araddr=0x100 same cycle, s0_arready=1, ostd_cnt=1; R beat rdata=0xA5.. with rlast -> s0_rvalid=1, s1_rvalid=0, ostd_cnt=0.
- Both ports request continuously, m_arready=1 -> grants alternate 0,1,0,1 over 4 cycles. With ARB_FIXED_PRIO_EN -> 1,1,1,1.
- s0 request with m_arready=0 for 3 cycles, s1 asserting arvalid meanwhile -> m_araddr stable and equal to s0's, s1_arready=0 throughout; s0 accepted in the 4th cycle.
- Issue 8 reads with no R -> ostd_cnt=8, m_arvalid=0 with pending arvalid. One R rlast -> next cycle a grant is allowed, ostd_cnt back to 8.
- Order s0, s1, s0 with responses of arlen=3 (4 beats each), s0_rready toggling -> beats delivered 4/4/4 to ports 0/1/0, m_rready follows the head port's rready.
- m_rvalid=1 with FIFO empty -> m_rready=1, rsp_err=1 and stays 1 until aresetn=0.
